mem_bus_initiator: RTL
======================

Name: mem_bus_initiator

Overview:
- Processor-side initiator for the memController bus. It is the other end of the responder that consumes memPkt_t traffic.
- Accepts one packet at a time: Type, Address and Data[4] flattened onto ports. Serialises it onto the multiplexed 16-bit AddrData bus: one address beat followed by a 4-beat data burst.
- For READ, captures the 4 returned words and presents them as one result.
- Sits between the testbench/processor model and memController.

Parameters:
- BURST_LEN, 4, data beats per packet; fixed to match memPkt_t.Data[4], beat counter is 2 bits.
- TURN_CYCLES, 1, idle turnaround cycles between address beat and first read beat (reads only).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- resetN  input  1  asynchronous active-low reset.
- pkt_valid  input  1  request strobe; packet fields valid while high.
- pkt_ready  output  1  initiator idle and able to accept; transfer occurs when pkt_valid && pkt_ready at a clk edge.
- pkt_type  input  1  pktType_t: WRITE=0, READ=1.
- pkt_addr  input  16  start address.
- pkt_data  input  64  write words; Data[i] = pkt_data[16i+15:16i].
- AddrValid  output  1  high only during the address beat.
- rw  output  1  1=read, 0=write; valid during address beat, held for the whole transaction.
- AddrData_out  output  16  address/write-data driven by initiator.
- AddrData_oe  output  1  high when initiator drives AddrData.
- AddrData_in  input  16  bus value driven by responder (read data).
- rd_data  output  64  captured read words, same packing as pkt_data.
- rd_valid  output  1  one-cycle pulse when rd_data is complete.
- done  output  1  one-cycle pulse at end of any transaction.

Behaviour:
- Reset (resetN low, async): state IDLE, pkt_ready=1, AddrValid=0, rw=0, AddrData_out=0, AddrData_oe=0, rd_data=0, rd_valid=0, done=0, beat counter=0, latched packet=0.
- States (state_t encoding): IDLE=STATE_A, ADDR=STATE_B, TURN=STATE_C, DATA=STATE_D, DONE=STATE_E. Unreachable encodings go to IDLE.
- IDLE:
  - pkt_ready=1.
  - On accept: latch type, addr and data, then go to ADDR. Packet inputs are ignored afterwards.
  - pkt_valid with pkt_ready=0 is held off; no queueing.
- ADDR (1 cycle):
  - AddrValid=1, AddrData_oe=1, AddrData_out=latched addr, rw=type.
  - Next state is DATA for WRITE, TURN for READ.
- TURN (TURN_CYCLES cycles, READ only): AddrValid=0, AddrData_oe=0.
- DATA (BURST_LEN cycles, beat counter 0..3):
  - WRITE: AddrData_oe=1, AddrData_out=Data[beat].
  - READ: AddrData_oe=0; on each edge, rd_data[16*beat+:16] <= AddrData_in.
  - Counter increments every cycle and wraps 3->0 on the exit to DONE.
- DONE (1 cycle):
  - done=1; rd_valid=1 if READ.
  - rd_data holds until the next READ's first captured beat.
  - Returns to IDLE; pkt_ready=1 in the following cycle.
- Latency from accept edge to done high:
  - WRITE: 1+4+1 = 6 cycles.
  - READ: 1+TURN_CYCLES+4+1 = 7 cycles at default.
- Back-to-back: minimum gap is one IDLE cycle between transactions.
- Bus exclusivity: AddrData_oe=0 in IDLE, TURN and READ DATA. Initiator never drives during a read beat.
- Reset mid-transaction: aborts immediately to reset values. The partial burst is discarded and no done pulse is issued.
- Outputs are registered (state-decoded from registered state). No combinational path from AddrData_in to any output.

Test Plan:
- Reset then idle -> all outputs at reset values, pkt_ready=1, AddrData_oe=0 for 10 cycles.
- WRITE addr=16'h1234, data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA} -> AddrValid one cycle with AddrData_out=1234 and rw=0; next 4 cycles AAAA, BBBB, CCCC, DDDD with oe=1; done pulses 6 cycles after accept, rd_valid=0.
- READ addr=16'h00F0, responder drives 1111, 2222, 3333, 4444 in the 4 beats after turnaround -> rw=1, oe=0 in TURN/DATA; rd_data=64'h4444_3333_2222_1111 with rd_valid and done pulses.
- Back-to-back READ then WRITE with pkt_valid held high -> second accept occurs exactly one cycle after the first done; pkt_ready=0 throughout the first transaction.
- resetN asserted during the 2nd write beat -> outputs return to reset values asynchronously, no done pulse; a subsequent READ completes normally.
- pkt_valid pulsed while busy with pkt_addr changing -> ignored; bus shows only the originally latched address and data.

Source files
------------

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: drives one packet onto the muxed 16-bit AddrData bus as an
// address beat plus a BURST_LEN data burst, capturing returned words for READs.
module mem_bus_initiator #(
    parameter int BURST_LEN   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_type,
    input  logic [15:0] pkt_addr,
    input  logic [63:0] pkt_data,
    output logic        AddrValid,
    output logic        rw,
    output logic [15:0] AddrData_out,
    output logic        AddrData_oe,
    input  logic [15:0] AddrData_in,
    output logic [63:0] rd_data,
    output logic        rd_valid,
    output logic        done
);

    typedef enum logic [2:0] {
        STATE_A = 3'd0,
        STATE_B = 3'd1,
        STATE_C = 3'd2,
        STATE_D = 3'd3,
        STATE_E = 3'd4
    } state_t;

    localparam state_t IDLE = STATE_A;
    localparam state_t ADDR = STATE_B;
    localparam state_t TURN = STATE_C;
    localparam state_t DATA = STATE_D;
    localparam state_t DONE = STATE_E;

    localparam logic PKT_WRITE = 1'b0;
    localparam logic PKT_READ  = 1'b1;

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [1:0]    LAST_BEAT = 2'(BURST_LEN - 1);
    localparam logic [TW-1:0] LAST_TURN = TW'(TURN_CYCLES - 1);

    state_t        state_q;
    state_t        state_d;
    logic          type_q;
    logic [15:0]   addr_q;
    logic [63:0]   data_q;
    logic [1:0]    beat_q;
    logic [TW-1:0] turn_q;
    logic [63:0]   rd_data_q;

    logic accept;
    logic turn_last;
    logic beat_last;
    logic [5:0] beat_lsb;

    assign accept    = (state_q == IDLE) && pkt_valid;
    assign turn_last = (turn_q == LAST_TURN);
    assign beat_last = (beat_q == LAST_BEAT);
    assign beat_lsb  = {beat_q, 4'b0000};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (type_q == PKT_READ && TURN_CYCLES > 0) begin
                    state_d = TURN;
                end else begin
                    state_d = DATA;
                end
            end
            TURN: begin
                if (turn_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet is frozen at accept; bus inputs only matter in read DATA beats.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            type_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            beat_q    <= '0;
            turn_q    <= '0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                type_q <= pkt_type;
                addr_q <= pkt_addr;
                data_q <= pkt_data;
            end
            if (state_q == TURN && !turn_last) begin
                turn_q <= turn_q + TW'(1);
            end else begin
                turn_q <= '0;
            end
            if (state_q == DATA) begin
                beat_q <= beat_q + 2'd1;
                if (type_q == PKT_READ) begin
                    rd_data_q[beat_lsb +: 16] <= AddrData_in;
                end
            end
        end
    end

    always_comb begin
        pkt_ready    = 1'b0;
        AddrValid    = 1'b0;
        rw           = 1'b0;
        AddrData_out = '0;
        AddrData_oe  = 1'b0;
        rd_valid     = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            IDLE: pkt_ready = 1'b1;
            ADDR: begin
                AddrValid    = 1'b1;
                AddrData_oe  = 1'b1;
                AddrData_out = addr_q;
                rw           = type_q;
            end
            TURN: rw = type_q;
            DATA: begin
                rw = type_q;
                if (type_q == PKT_WRITE) begin
                    AddrData_oe  = 1'b1;
                    AddrData_out = data_q[beat_lsb +: 16];
                end
            end
            DONE: begin
                rw       = type_q;
                done     = 1'b1;
                rd_valid = type_q;
            end
            default: ;
        endcase
    end

    assign rd_data = rd_data_q;

endmodule
